// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state codes and the
// default alarm duration used by countdown_ctrl.
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_RUN      = 3'd3,
        ST_PAUSE    = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam int ALARM_TICKS_DEF = 10;

endpackage

// File: rtl/countdown_ctrl_if.sv
// Signal bundle between the button/tick generators, the digit-counter chain
// and countdown_ctrl. The slave modport is the controller's view.
interface countdown_ctrl_if;

    // No valid/ready pairs here: every input strobe (tick_1hz, btn_*) is a
    // single-cycle pulse acted on in the cycle it is high, and every output
    // pulse (dec_sec, inc_min, inc_hour) is high for exactly one cycle, one
    // clock after the input that caused it. Receivers must not back-pressure.
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_start;
    logic       time_zero;
    logic       dec_sec;
    logic       inc_min;
    logic       inc_hour;
    logic       blink;
    logic       sel_hour;
    logic       alarm;
    logic [2:0] state;

    modport master (
        output tick_1hz, btn_mode, btn_inc, btn_start, time_zero,
        input  dec_sec, inc_min, inc_hour, blink, sel_hour, alarm, state
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc, btn_start, time_zero,
        output dec_sec, inc_min, inc_hour, blink, sel_hour, alarm, state
    );

endinterface

// File: rtl/pulse_reg.sv
// Registered one-shot: q follows a single-cycle request one clock later.
module pulse_reg (
    input  logic clk_out,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) q <= 1'b0;
        else        q <= d;
    end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown timer control FSM: set-mode field editing, run/pause, alarm
// timeout, and the registered pulses that drive the digit-counter chain.
module countdown_ctrl
    import timer_pkg::*;
#(
    parameter int ALARM_TICKS = ALARM_TICKS_DEF,
    parameter int CW          = 4
) (
    input  logic             clk_out,
    input  logic             rst_n,
    countdown_ctrl_if.slave  bus
);

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          blink_q;
    logic          blink_d;
    logic          dec_req;
    logic          inc_min_req;
    logic          inc_hour_req;
    logic          any_btn;
    logic          cnt_last;
    logic          in_set;

    assign any_btn  = bus.btn_start | bus.btn_mode | bus.btn_inc;
    assign cnt_last = (cnt_q == CW'(ALARM_TICKS - 1));
    assign in_set   = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Button priority start > mode > inc; time_zero only matters on ticks or start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.btn_start) begin
                    if (!bus.time_zero) state_d = ST_RUN;
                end else if (bus.btn_mode) begin
                    state_d = ST_SET_HOUR;
                end
            end
            ST_SET_HOUR: begin
                if (bus.btn_start)     state_d = bus.time_zero ? ST_IDLE : ST_RUN;
                else if (bus.btn_mode) state_d = ST_SET_MIN;
            end
            ST_SET_MIN: begin
                if (bus.btn_start)     state_d = bus.time_zero ? ST_IDLE : ST_RUN;
                else if (bus.btn_mode) state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (bus.btn_mode)                       state_d = ST_PAUSE;
                else if (bus.tick_1hz && bus.time_zero) state_d = ST_DONE;
            end
            ST_PAUSE: begin
                if (bus.btn_start)     state_d = ST_RUN;
                else if (bus.btn_mode) state_d = ST_IDLE;
            end
            ST_DONE: begin
                if (any_btn)                        state_d = ST_IDLE;
                else if (bus.tick_1hz && cnt_last)  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dec_req      = (state_q == ST_RUN) && bus.tick_1hz && !bus.btn_mode && !bus.time_zero;
        inc_hour_req = (state_q == ST_SET_HOUR) && bus.btn_inc && !bus.btn_mode && !bus.btn_start;
        inc_min_req  = (state_q == ST_SET_MIN) && bus.btn_inc && !bus.btn_mode && !bus.btn_start;
        bus.sel_hour = (state_q == ST_SET_HOUR);
        bus.alarm    = (state_q == ST_DONE);
        bus.state    = state_q;
        bus.blink    = blink_q;
    end

    // Blink phase restarts dark whenever the FSM moves to another state.
    always_comb begin
        blink_d = 1'b0;
        if (state_d == state_q && in_set)
            blink_d = bus.tick_1hz ? ~blink_q : blink_q;
        cnt_d = '0;
        if (state_d == ST_DONE && state_q == ST_DONE)
            cnt_d = bus.tick_1hz ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            blink_q <= blink_d;
            cnt_q   <= cnt_d;
        end
    end

    pulse_reg u_dec_sec  (.clk_out(clk_out), .rst_n(rst_n), .d(dec_req),      .q(bus.dec_sec));
    pulse_reg u_inc_min  (.clk_out(clk_out), .rst_n(rst_n), .d(inc_min_req),  .q(bus.inc_min));
    pulse_reg u_inc_hour (.clk_out(clk_out), .rst_n(rst_n), .d(inc_hour_req), .q(bus.inc_hour));

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the timer's rules.
module tb_countdown_ctrl;

    localparam int ALARM_TICKS = 10;

    logic clk_out = 1'b0;
    logic rst_n   = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    countdown_ctrl_if bus ();

    countdown_ctrl #(.ALARM_TICKS(ALARM_TICKS), .CW(4)) dut (
        .clk_out (clk_out),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_out = ~clk_out;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model: expected visible outputs after each clock.
    int m_state;
    int m_cnt;
    bit m_blink, m_dec, m_imin, m_ihour;

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_blink = 0; m_dec = 0; m_imin = 0; m_ihour = 0;
    endtask

    task automatic model_step(input bit tick, mode, inc, start, tz);
        int ns;
        bit d, im, ih;
        ns = m_state; d = 0; im = 0; ih = 0;
        case (m_state)
            0: if (start) ns = tz ? 0 : 3; else if (mode) ns = 1;
            1, 2: begin
                if (start)     ns = tz ? 0 : 3;
                else if (mode) ns = (m_state == 1) ? 2 : 0;
                else if (inc) begin
                    if (m_state == 1) ih = 1; else im = 1;
                end
            end
            3: if (mode) ns = 4; else if (tick) begin if (tz) ns = 5; else d = 1; end
            4: if (start) ns = 3; else if (mode) ns = 0;
            5: begin
                if (start || mode || inc) ns = 0;
                else if (tick) begin
                    if (m_cnt + 1 == ALARM_TICKS) ns = 0;
                    else m_cnt = m_cnt + 1;
                end
            end
            default: ns = 0;
        endcase
        if (ns != m_state) m_blink = 0;
        else if ((ns == 1 || ns == 2) && tick) m_blink = !m_blink;
        if (ns != 5) m_cnt = 0;
        m_state = ns; m_dec = d; m_imin = im; m_ihour = ih;
    endtask

    task automatic clear_inputs();
        bus.tick_1hz = 0; bus.btn_mode = 0; bus.btn_inc = 0; bus.btn_start = 0; bus.time_zero = 0;
    endtask

    // One clock: drive at negedge, model advances, return just after posedge.
    task automatic cyc(input bit tick, mode, inc, start, tz);
        @(negedge clk_out);
        bus.tick_1hz = tick; bus.btn_mode = mode; bus.btn_inc = inc;
        bus.btn_start = start; bus.time_zero = tz;
        model_step(tick, mode, inc, start, tz);
        @(posedge clk_out);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_out);
        clear_inputs();
        rst_n = 0;
        model_reset();
        @(negedge clk_out);
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        total++;
        if (bus.dec_sec !== 1'b1 || bus.state !== 3'd3) begin
            bad++;
            $display("FAIL reset_setup: dec_sec=%b state=%0d, required dec_sec=1 state=3", bus.dec_sec, bus.state);
        end
        #2 rst_n = 0;
        #1;
        total++;
        if (bus.state !== 3'd0 || bus.dec_sec !== 1'b0 || bus.inc_min !== 1'b0 || bus.inc_hour !== 1'b0 ||
            bus.blink !== 1'b0 || bus.alarm !== 1'b0 || bus.sel_hour !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: state=%0d dec=%b imin=%b ihour=%b blink=%b alarm=%b sel=%b, required all 0",
                     bus.state, bus.dec_sec, bus.inc_min, bus.inc_hour, bus.blink, bus.alarm, bus.sel_hour);
        end
        @(negedge clk_out);
        clear_inputs();
        model_reset();
        rst_n = 1;
    endtask

    task automatic test_set_fields();
        int hour_pulses = 0;
        int min_pulses  = 0;
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) cyc(0, 1, 0, 0, 0);
            cyc(0, 0, 1, 0, 0);
            total++;
            if (bus.inc_hour !== (i < 3) || bus.inc_min !== (i >= 3)) begin
                bad++;
                $display("FAIL set_pulse[%0d]: inc_hour=%b inc_min=%b, required %b %b", i, bus.inc_hour, bus.inc_min, i < 3, i >= 3);
            end
            hour_pulses += bus.inc_hour; min_pulses += bus.inc_min;
            cyc(0, 0, 0, 0, 0);
            total++;
            if (bus.inc_hour !== 1'b0 || bus.inc_min !== 1'b0) begin
                bad++;
                $display("FAIL set_width[%0d]: inc_hour=%b inc_min=%b, required 0 0", i, bus.inc_hour, bus.inc_min);
            end
        end
        total++;
        if (hour_pulses != 3 || min_pulses != 2 || bus.state !== 3'd2 || bus.sel_hour !== 1'b0) begin
            bad++;
            $display("FAIL set_final: hour=%0d min=%0d state=%0d sel=%b, required 3 2 2 0", hour_pulses, min_pulses, bus.state, bus.sel_hour);
        end
        cyc(0, 1, 0, 0, 0);
    endtask

    task automatic test_run_to_done();
        int pulses = 0;
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0, 0);
            pulses += bus.dec_sec;
            cyc(0, 0, 0, 0, 0);
            total++;
            if (bus.dec_sec !== 1'b0) begin
                bad++;
                $display("FAIL run_width[%0d]: dec_sec=%b, required 0", i, bus.dec_sec);
            end
        end
        cyc(1, 0, 0, 0, 1);
        total++;
        if (pulses != 5 || bus.dec_sec !== 1'b0 || bus.state !== 3'd5 || bus.alarm !== 1'b1) begin
            bad++;
            $display("FAIL run_done: pulses=%0d dec=%b state=%0d alarm=%b, required 5 0 5 1", pulses, bus.dec_sec, bus.state, bus.alarm);
        end
    endtask

    task automatic test_alarm_timeout();
        for (int i = 1; i <= ALARM_TICKS; i++) begin
            cyc(0, 0, 0, 0, 1);
            cyc(1, 0, 0, 0, 1);
            total++;
            if (i < ALARM_TICKS && (bus.state !== 3'd5 || bus.alarm !== 1'b1)) begin
                bad++;
                $display("FAIL alarm_hold[%0d]: state=%0d alarm=%b, required 5 1", i, bus.state, bus.alarm);
            end else if (i == ALARM_TICKS && (bus.state !== 3'd0 || bus.alarm !== 1'b0)) begin
                bad++;
                $display("FAIL alarm_timeout: state=%0d alarm=%b, required 0 0", bus.state, bus.alarm);
            end
        end
    endtask

    task automatic test_pause_priority();
        cyc(0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0);
        total++;
        if (bus.state !== 3'd4 || bus.dec_sec !== 1'b0) begin
            bad++;
            $display("FAIL pause_vs_tick: state=%0d dec=%b, required 4 0", bus.state, bus.dec_sec);
        end
        cyc(1, 0, 0, 0, 0);
        total++;
        if (bus.state !== 3'd4 || bus.dec_sec !== 1'b0) begin
            bad++;
            $display("FAIL pause_ignores_tick: state=%0d dec=%b, required 4 0", bus.state, bus.dec_sec);
        end
        cyc(0, 1, 0, 1, 0);
        total++;
        if (bus.state !== 3'd3) begin
            bad++;
            $display("FAIL start_over_mode: state=%0d, required 3", bus.state);
        end
    endtask

    task automatic test_start_at_zero();
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1);
        total++;
        if (bus.state !== 3'd0 || bus.dec_sec !== 1'b0 || bus.inc_min !== 1'b0 || bus.inc_hour !== 1'b0) begin
            bad++;
            $display("FAIL start_zero: state=%0d dec=%b imin=%b ihour=%b, required 0 0 0 0",
                     bus.state, bus.dec_sec, bus.inc_min, bus.inc_hour);
        end
    endtask

    task automatic test_illegal_state();
        cyc(0, 0, 0, 1, 0);
        @(negedge clk_out);
        clear_inputs();
        force dut.state_q = 3'd7;
        #1;
        release dut.state_q;
        @(posedge clk_out);
        #1;
        total++;
        if (bus.state !== 3'd0) begin
            bad++;
            $display("FAIL illegal_state: state=%0d, required 0", bus.state);
        end
        model_reset();
    endtask

    task automatic test_random();
        bit tick, mode, inc, start, tz;
        for (int n = 0; n < 3000; n++) begin
            tick  = ($urandom_range(0, 2) == 0);
            mode  = ($urandom_range(0, 11) == 0);
            inc   = ($urandom_range(0, 5) == 0);
            start = ($urandom_range(0, 13) == 0);
            tz    = ($urandom_range(0, 4) == 0);
            cyc(tick, mode, inc, start, tz);
            total++;
            if (bus.state !== 3'(m_state) || bus.alarm !== (m_state == 5) || bus.sel_hour !== (m_state == 1)) begin
                bad++;
                $display("FAIL rand_state[%0d]: state=%0d alarm=%b sel=%b, required %0d %b %b",
                         n, bus.state, bus.alarm, bus.sel_hour, m_state, m_state == 5, m_state == 1);
            end
            total++;
            if (bus.dec_sec !== m_dec || bus.inc_min !== m_imin || bus.inc_hour !== m_ihour) begin
                bad++;
                $display("FAIL rand_pulse[%0d]: dec=%b imin=%b ihour=%b, required %b %b %b",
                         n, bus.dec_sec, bus.inc_min, bus.inc_hour, m_dec, m_imin, m_ihour);
            end
            total++;
            if (bus.blink !== m_blink) begin
                bad++;
                $display("FAIL rand_blink[%0d]: blink=%b, required %b", n, bus.blink, m_blink);
            end
        end
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_set_fields();
        test_run_to_done();
        test_alarm_timeout();
        test_pause_priority();
        test_start_at_zero();
        test_illegal_state();
        do_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
